dmac_sfr_arbiter: RTL and testbench
===================================

// Module: dmac_sfr_arbiter
// PURPOSE
//  Shares one SRAM-like SFR port (wren/rden/addr/wdata, rdata one cycle after rden) between N requesters,
//  e.g. the host APB front-end and the DMA engine's descriptor/status writer.
//  Round-robin arbitration; one access in flight at a time; per-requester req/ack handshake.
//  Sits between the requesters and the DMAC SFR file.
// PARAMETERS
//  N_REQ   2    number of requesters (2..8)
//  AW      4    SFR word-address width
//  DW      32   data width
// PORTS
//  clk      in   1         clock; single clock domain
//  rst_n    in   1         reset, synchronous, active-low
//  req_i    in   N_REQ     access request per requester; held until its ack_o
//  we_i     in   N_REQ     1=write, 0=read; stable while req_i high
//  addr_i   in   N_REQ*AW  packed word address per requester; stable while req_i high
//  wdata_i  in   N_REQ*DW  packed write data per requester; stable while req_i high
//  ack_o    out  N_REQ     one-cycle completion pulse to the granted requester
//  rdata_o  out  DW        read data; valid in the ack_o cycle of a read
//  wren_o   out  1         SFR write strobe (registered)
//  rden_o   out  1         SFR read strobe (registered)
//  addr_o   out  AW        SFR address (registered)
//  wdata_o  out  DW        SFR write data (registered)
//  rdata_i  in   DW        SFR read data; valid the cycle after rden_o
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, ack_o=0, wren_o=rden_o=0, addr_o=0, wdata_o=0, rdata_o=0,
//   rr pointer=0, grant index=0. Reset mid-access aborts it: no ack is issued; the requester re-requests.
//  FSM states: IDLE, ISSUE, CAPT, RESP.
//   IDLE : if any req_i, pick winner g (round-robin from pointer), latch g, we/addr/wdata -> ISSUE.
//          No req -> stay IDLE, strobes 0.
//   ISSUE: exactly one of wren_o/rden_o high for one cycle, addr_o/wdata_o = latched values.
//          write -> RESP; read -> CAPT.
//   CAPT : rdata_i captured into rdata_o -> RESP. Strobes 0.
//   RESP : ack_o[g]=1 for exactly this cycle; pointer <= (g+1) mod N_REQ -> IDLE.
//  Latency (req sampled in IDLE at cycle T): strobe in T+1; write ack in T+2; read ack in T+3.
//  Back-to-back: next arbitration in the IDLE cycle after RESP; max rate 1 write/3 cycles, 1 read/4 cycles.
//  Handshake: requester deasserts req_i (or presents the next request) in the cycle after its ack_o;
//   a req_i still high in the IDLE after RESP is treated as a new request.
//  Round-robin: search order pointer, pointer+1, ... wrapping at N_REQ-1 -> 0; a requester waits at most
//   N_REQ-1 grants. Simultaneous requests with pointer=0: lowest index wins.
//  req_i dropped before ack (protocol violation): in-flight access still completes and ack still pulses.
//  At most one ack_o bit high per cycle; wren_o and rden_o never high together.
//  rdata_o holds its value until the next read's CAPT; undefined meaning outside read ack cycles.
//  addr_o/wdata_o hold their last values when idle (no gating required).
// STRUCTURE
//  dmac_pkg: typedef enum logic [1:0] {S_IDLE,S_ISSUE,S_CAPT,S_RESP} sfr_arb_state_t; DMAC_DW=32, DMAC_AW=4.
//  Sub-module dmac_rr_picker (combinational): inputs req vector and pointer; outputs valid and winner
//   index. Reusable by the channel arbiter.
//  Top: FSM, grant/command latches, registered SFR outputs, rdata capture, ack decode.
// TESTING
//  1 reset: rst_n=0 2 cycles with req_i=2'b11 -> all outputs 0, no strobe, no ack; first grant to req0 after release.
//  2 single write: req0, we=1, addr=3, wdata=32'hCAFE_0001 at T -> wren_o=1, addr_o=3 at T+1; ack_o=2'b01 at T+2.
//  3 single read: SFR model returns 32'hA5A5_5A5A at T+2 -> rden_o at T+1; ack_o[1]=1, rdata_o=32'hA5A5_5A5A at T+3.
//  4 contention: req_i=2'b11 held continuously -> grants alternate 0,1,0,1; exactly one ack per transaction.
//  5 reset mid-read: rst_n=0 during CAPT -> no ack; after release the same req re-granted, completes with correct data.
//  6 random: N_REQ=4, random reqs/addrs vs scoreboard SFR model -> data matches, no starvation >3 grants.

Source files
------------

// File: rtl/dmac_pkg.sv
// Shared types and constants for the DMAC SFR access path.
package dmac_pkg;

  localparam int unsigned DMAC_DW = 32;
  localparam int unsigned DMAC_AW = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPT,
    S_RESP
  } sfr_arb_state_t;

  // Round-robin successor of index g among n requesters.
  function automatic int unsigned rr_next_idx(input int unsigned g, input int unsigned n);
    return (g + 1) % n;
  endfunction

endpackage

// File: rtl/dmac_rr_picker.sv
// Combinational round-robin picker: first active request at or after ptr, wrapping.
module dmac_rr_picker #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned IW    = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic             valid_c,
  output logic [IW-1:0]    winner_c
);

  int unsigned cand;

  always_comb begin
    valid_c  = 1'b0;
    winner_c = '0;
    cand     = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = (32'(ptr) + i) % N_REQ;
      if (!valid_c && req[IW'(cand)]) begin
        valid_c  = 1'b1;
        winner_c = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/dmac_sfr_arbiter.sv
// Round-robin arbiter sharing one SRAM-like SFR port among N_REQ requesters,
// one access in flight, req/ack handshake per requester.
module dmac_sfr_arbiter
  import dmac_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned AW    = DMAC_AW,
  parameter int unsigned DW    = DMAC_DW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]    req_i,
  input  logic [N_REQ-1:0]    we_i,
  input  logic [N_REQ*AW-1:0] addr_i,
  input  logic [N_REQ*DW-1:0] wdata_i,
  output logic [N_REQ-1:0]    ack_o,
  output logic [DW-1:0]       rdata_o,
  output logic                wren_o,
  output logic                rden_o,
  output logic [AW-1:0]       addr_o,
  output logic [DW-1:0]       wdata_o,
  input  logic [DW-1:0]       rdata_i
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  sfr_arb_state_t state;
  logic [IW-1:0]  rr_ptr;
  logic [IW-1:0]  gnt;
  logic           cmd_we;
  logic           pick_valid_c;
  logic [IW-1:0]  pick_idx_c;

  dmac_rr_picker #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_picker (
    .req      (req_i),
    .ptr      (rr_ptr),
    .valid_c  (pick_valid_c),
    .winner_c (pick_idx_c)
  );

  // Arbitration FSM; addr_o/wdata_o double as the latched command and hold when idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      rr_ptr  <= '0;
      gnt     <= '0;
      cmd_we  <= 1'b0;
      ack_o   <= '0;
      wren_o  <= 1'b0;
      rden_o  <= 1'b0;
      addr_o  <= '0;
      wdata_o <= '0;
      rdata_o <= '0;
    end else begin
      ack_o  <= '0;
      wren_o <= 1'b0;
      rden_o <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (pick_valid_c) begin
            gnt     <= pick_idx_c;
            cmd_we  <= we_i[pick_idx_c];
            wren_o  <= we_i[pick_idx_c];
            rden_o  <= !we_i[pick_idx_c];
            addr_o  <= addr_i[32'(pick_idx_c)*AW +: AW];
            wdata_o <= wdata_i[32'(pick_idx_c)*DW +: DW];
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (cmd_we) begin
            ack_o[gnt] <= 1'b1;
            state      <= S_RESP;
          end else begin
            state <= S_CAPT;
          end
        end
        S_CAPT: begin
          rdata_o    <= rdata_i;
          ack_o[gnt] <= 1'b1;
          state      <= S_RESP;
        end
        S_RESP: begin
          rr_ptr <= IW'(rr_next_idx(32'(gnt), N_REQ));
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmac_sfr_arbiter.sv
// Scoreboard bench for dmac_sfr_arbiter: directed latency/arbitration cases plus random traffic.
module tb_dmac_sfr_arbiter;

  localparam int N  = 4;
  localparam int AW = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_i, we_i, ack_o;
  logic [N*AW-1:0] addr_i;
  logic [N*DW-1:0] wdata_i;
  logic [DW-1:0]   rdata_o, wdata_o, rdata_i;
  logic            wren_o, rden_o;
  logic [AW-1:0]   addr_o;

  typedef struct {
    bit          we;
    logic [3:0]  addr;
    logic [31:0] data;
  } txn_t;

  txn_t        exp_q[N][$];
  logic [31:0] mem[16];
  logic [31:0] shadow[16];
  int          waits[N];
  int          total = 0;
  int          bad   = 0;
  int          exp_order[4];
  int          got;
  int          mon_s;
  txn_t        mon_t;

  always #5 clk = ~clk;

  dmac_sfr_arbiter #(.N_REQ(N), .AW(AW), .DW(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   (req_i),
    .we_i    (we_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .ack_o   (ack_o),
    .rdata_o (rdata_o),
    .wren_o  (wren_o),
    .rden_o  (rden_o),
    .addr_o  (addr_o),
    .wdata_o (wdata_o),
    .rdata_i (rdata_i)
  );

  // SFR file: read data appears the cycle after rden_o, junk otherwise.
  always @(posedge clk) begin
    if (wren_o) mem[addr_o] <= wdata_o;
    if (rden_o) rdata_i <= mem[addr_o];
    else        rdata_i <= $urandom;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic issue(input int k, input bit we, input logic [3:0] a, input logic [31:0] d);
    txn_t t;
    we_i[k]              = we;
    addr_i[k*AW +: AW]   = a;
    wdata_i[k*DW +: DW]  = d;
    t.we   = we;
    t.addr = a;
    t.data = we ? d : shadow[a];
    if (we) shadow[a] = d;
    exp_q[k].push_back(t);
    req_i[k] = 1'b1;
  endtask

  task automatic wait_ack(input int k);
    int n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (ack_o[k]) break;
      n++;
    end
    total++;
    if (n >= 40) begin
      bad++;
      $display("FAIL ack_timeout: requester %0d got no ack within 40 cycles", k);
    end
  endtask

  task automatic wait_any(output int idx);
    int n = 0;
    idx = -1;
    while (n < 40 && idx < 0) begin
      @(negedge clk);
      for (int j = 0; j < N; j++) if (ack_o[j]) idx = j;
      n++;
    end
    total++;
    if (idx < 0) begin
      bad++;
      $display("FAIL any_ack_timeout: no ack within 40 cycles");
    end
  endtask

  task automatic drive(input int k);
    @(negedge clk);
    #1;
    for (int n = 0; n < 30; n++) begin
      logic [3:0] a;
      a = {2'(k), 2'($urandom_range(0, 3))};
      issue(k, 1'($urandom_range(0, 1)), a, $urandom);
      wait_ack(k);
      #1;
      req_i[k] = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        #1;
      end
    end
  endtask

  // Monitor: strobe/ack legality, command contents, read data and waiting bound.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("strobe_excl", 32'(wren_o & rden_o), 32'd0);
      chk("ack_onehot", 32'($countones(ack_o) > 1), 32'd0);
      if (wren_o || rden_o) begin
        mon_s = int'(addr_o[3:2]);
        if (exp_q[mon_s].size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_strobe: addr %h with no pending request", addr_o);
        end else begin
          mon_t = exp_q[mon_s][0];
          chk("strobe_kind", 32'(wren_o), 32'(mon_t.we));
          chk("strobe_addr", 32'(addr_o), 32'(mon_t.addr));
          if (mon_t.we) chk("strobe_wdata", wdata_o, mon_t.data);
          chk("wait_bound", 32'(waits[mon_s] <= N - 1), 32'd1);
          waits[mon_s] = 0;
          for (int j = 0; j < N; j++)
            if (j != mon_s && exp_q[j].size() > 0) waits[j]++;
        end
      end
      for (int k = 0; k < N; k++) begin
        if (ack_o[k]) begin
          if (exp_q[k].size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_ack: requester %0d with nothing pending", k);
          end else begin
            mon_t = exp_q[k].pop_front();
            if (!mon_t.we) chk("rdata", rdata_o, mon_t.data);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_order = '{0, 1, 0, 1};
    for (int i = 0; i < 16; i++) begin
      mem[i]    = 32'h0101_0101 * 32'(i);
      shadow[i] = mem[i];
    end
    mem[5] = 32'hA5A5_5A5A;
    shadow[5] = 32'hA5A5_5A5A;
    for (int k = 0; k < N; k++) waits[k] = 0;
    rst_n   = 1'b0;
    req_i   = '0;
    we_i    = '0;
    addr_i  = '0;
    wdata_i = '0;

    // 1: reset with both requests pending, then first grant to req0
    issue(0, 1'b1, 4'd1, 32'h1111_0000);
    issue(1, 1'b0, 4'd6, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 32'(ack_o), 32'd0);
    chk("rst_wren", 32'(wren_o), 32'd0);
    chk("rst_rden", 32'(rden_o), 32'd0);
    chk("rst_addr", 32'(addr_o), 32'd0);
    chk("rst_wdata", wdata_o, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("first_grant_wren", 32'(wren_o), 32'd1);
    chk("first_grant_addr", 32'(addr_o), 32'd1);
    wait_ack(0);
    chk("first_grant_ack", 32'(ack_o), 32'b0001);
    #1 req_i[0] = 1'b0;
    wait_ack(1);
    #1 req_i[1] = 1'b0;

    // 2: single write latency
    @(negedge clk);
    #1 issue(0, 1'b1, 4'd3, 32'hCAFE_0001);
    @(negedge clk);
    chk("wr_strobe", 32'(wren_o), 32'd1);
    chk("wr_no_rden", 32'(rden_o), 32'd0);
    chk("wr_addr", 32'(addr_o), 32'd3);
    chk("wr_data", wdata_o, 32'hCAFE_0001);
    @(negedge clk);
    chk("wr_ack", 32'(ack_o), 32'b0001);
    #1 req_i[0] = 1'b0;

    // 3: single read latency
    @(negedge clk);
    #1 issue(1, 1'b0, 4'd5, 32'h0);
    @(negedge clk);
    chk("rd_strobe", 32'(rden_o), 32'd1);
    chk("rd_addr", 32'(addr_o), 32'd5);
    @(negedge clk);
    chk("rd_no_early_ack", 32'(ack_o), 32'd0);
    @(negedge clk);
    chk("rd_ack", 32'(ack_o), 32'b0010);
    chk("rd_data", rdata_o, 32'hA5A5_5A5A);
    #1 req_i[1] = 1'b0;

    // 4: contention, both held; grants must alternate
    @(negedge clk);
    #1;
    issue(0, 1'b1, 4'd0, 32'h0000_AAAA);
    issue(1, 1'b1, 4'd7, 32'h0000_BBBB);
    for (int i = 0; i < 4; i++) begin
      wait_any(got);
      chk("rr_order", 32'(got), 32'(exp_order[i]));
      #1;
      if (got >= 0) begin
        if (i < 2) issue(got, 1'b1, {2'(got), 2'd2}, $urandom);
        else req_i[got] = 1'b0;
      end
    end

    // 5: reset during CAPT aborts the read; it is re-granted and completes
    @(negedge clk);
    #1 issue(0, 1'b0, 4'd2, 32'h0);
    @(negedge clk);
    chk("abort_rd_strobe", 32'(rden_o), 32'd1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("abort_no_ack", 32'(ack_o), 32'd0);
    #1 rst_n = 1'b1;
    wait_ack(0);
    chk("abort_regrant_ack", 32'(ack_o), 32'b0001);
    chk("abort_regrant_data", rdata_o, shadow[2]);
    #1 req_i[0] = 1'b0;

    // 6: random traffic from all requesters, disjoint address regions
    for (int k = 0; k < N; k++) begin
      fork
        automatic int kk = k;
        drive(kk);
      join_none
    end
    wait fork;

    repeat (4) @(negedge clk);
    for (int k = 0; k < N; k++) chk("drained", 32'(exp_q[k].size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
